// File: rtl/ysyx_20020207_ifu.sv
// rtl/ysyx_20020207_ifu.sv - instruction fetch unit, AXI4-Lite-style read master feeding decode
// Build option: CONFIG_PIPELINE_EN (defined: speculative pc+4 fetch with jump redirect; undefined: wait for writeback)
module ysyx_20020207_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
`ifdef CONFIG_PIPELINE_EN
  input  logic        jump,
  input  logic [31:0] jump_pc,
`else
  input  logic        wb_valid,
  input  logic [31:0] next_pc,
`endif
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, WAIT_WB} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        drop;
  logic        redirect;
  logic [31:0] redirect_pc;

`ifdef CONFIG_PIPELINE_EN
  assign redirect    = jump;
  assign redirect_pc = jump_pc;
`else
  // no redirect source without the pipeline; drop then never sets
  assign redirect    = 1'b0;
  assign redirect_pc = 32'h0;
`endif

  // handshake strobes are pure state decodes, forced low while reset is asserted
  assign arvalid   = (state == REQ)  && !reset;
  assign rready    = (state == RESP) && !reset;
  assign out_valid = (state == HOLD) && !reset;
  assign araddr    = req_addr;

  // fetch FSM: pc tracking, request address latch, redirect/drop handling and output capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      drop      <= 1'b0;
      inst_out  <= 32'h0;
      pc_out    <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      if (redirect) pc <= redirect_pc;
      case (state)
        IDLE: begin
          state    <= REQ;
          req_addr <= redirect ? redirect_pc : pc;
        end
        REQ: begin
          // the address already on the bus stays; its response gets thrown away
          if (redirect) drop <= 1'b1;
          if (arready) state <= RESP;
        end
        RESP: begin
          if (rvalid) begin
            if (drop || redirect) begin
              drop     <= 1'b0;
              state    <= REQ;
              req_addr <= redirect ? redirect_pc : pc;
            end else begin
              inst_out  <= rdata;
              pc_out    <= pc;
              fetch_err <= |rresp;
              state     <= HOLD;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            state    <= REQ;
            req_addr <= redirect_pc;
          end else if (out_ready) begin
`ifdef CONFIG_PIPELINE_EN
            pc       <= pc + 32'd4;
            req_addr <= pc + 32'd4;
            state    <= REQ;
`else
            state    <= WAIT_WB;
`endif
          end
        end
`ifndef CONFIG_PIPELINE_EN
        WAIT_WB: begin
          if (wb_valid) begin
            pc       <= next_pc;
            req_addr <= next_pc;
            state    <= REQ;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_ifu.sv
// tb/tb_ysyx_20020207_ifu.sv - randomized bench for ysyx_20020207_ifu with a transaction-level model
module tb_ysyx_20020207_ifu;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
`ifdef CONFIG_PIPELINE_EN
  logic        jump;
  logic [31:0] jump_pc;
`else
  logic        wb_valid;
  logic [31:0] next_pc;
`endif
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        fetch_err;

  always #5 clock = ~clock;

  ysyx_20020207_ifu dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CONFIG_PIPELINE_EN
    .jump      (jump),
    .jump_pc   (jump_pc),
`else
    .wb_valid  (wb_valid),
    .next_pc   (next_pc),
`endif
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst_out  (inst_out),
    .pc_out    (pc_out),
    .fetch_err (fetch_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // which channel the fetch unit currently owes the outside world
  typedef enum {P_AR, P_R, P_OUT, P_WB} phase_t;

  phase_t      phase;
  logic [31:0] want, cur_ar, rd_addr, rd_data, ex_inst, ex_pc;
  logic [1:0]  rd_resp;
  logic        ex_err, discard, fresh;
  int          rd_lat, n_req, n_del, n_wb, hold_cnt, jpin;
  logic        jmp, wbv;
  logic [31:0] jpc, wbpc;

  initial begin
    reset = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; out_ready = 1'b0;
`ifdef CONFIG_PIPELINE_EN
    jump = 1'b0; jump_pc = 32'h0;
`else
    wb_valid = 1'b0; next_pc = 32'h0;
`endif
    jmp = 1'b0; jpc = 32'h0; wbv = 1'b0; wbpc = 32'h0;
    phase = P_AR; want = RESET_PC; cur_ar = RESET_PC; discard = 1'b0; fresh = 1'b0;
    rd_addr = 32'h0; rd_data = 32'h0; rd_resp = 2'b00; rd_lat = 0;
    ex_inst = 32'h0; ex_pc = 32'h0; ex_err = 1'b0;
    n_req = 0; n_del = 0; n_wb = 0; hold_cnt = 0; jpin = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_arvalid", 32'(arvalid), 32'h0);
    chk("reset_rready", 32'(rready), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_inst_out", inst_out, 32'h0);
    chk("reset_fetch_err", 32'(fetch_err), 32'h0);
    reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      // compare DUT against the model
      chk("arvalid", 32'(arvalid), 32'(phase == P_AR));
      chk("rready", 32'(rready), 32'(phase == P_R));
      chk("out_valid", 32'(out_valid), 32'(phase == P_OUT));
      if (phase == P_AR) chk("araddr", araddr, cur_ar);
      if (phase == P_OUT) begin
        chk("inst_out", inst_out, ex_inst);
        chk("pc_out", pc_out, ex_pc);
        chk("fetch_err", 32'(fetch_err), 32'(ex_err));
        if (fresh) begin
          if (n_del == 0) begin
            chk("first_inst", inst_out, 32'h0000_0013);
            chk("first_pc", pc_out, 32'h3000_0000);
          end
          if (n_del == 2) chk("err_pin", 32'(fetch_err), 32'h1);
          if (n_del == 3) chk("err_clear_pin", 32'(fetch_err), 32'h0);
`ifdef CONFIG_PIPELINE_EN
          if (n_del < 4) chk("seq_pc", pc_out, 32'h3000_0000 + 32'(n_del) * 32'd4);
          if (jpin == 2) begin
            chk("jump_pc_out", pc_out, 32'h3000_0100);
            jpin = 3;
          end
`endif
          fresh = 1'b0;
        end
        if (n_del == 1 && hold_cnt == 5) begin
          chk("hold5_valid", 32'(out_valid), 32'h1);
          chk("hold5_arvalid", 32'(arvalid), 32'h0);
        end
      end

      // drive the next cycle's inputs
      arready = ($urandom_range(0, 2) != 0);
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
      if (phase == P_R && rd_lat == 0) begin
        rvalid = 1'b1; rdata = rd_data; rresp = rd_resp;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (phase == P_OUT && n_del == 1 && hold_cnt < 5) out_ready = 1'b0;
      jmp = 1'b0; jpc = $urandom;
`ifdef CONFIG_PIPELINE_EN
      if (phase == P_R && n_req == 7 && jpin == 0) begin
        jmp = 1'b1; jpc = 32'h3000_0100; rvalid = 1'b0; jpin = 1;
      end else if (jpin == 3 && $urandom_range(0, 7) == 0) begin
        jmp = 1'b1;
        jpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : RESET_PC + 32'($urandom_range(0, 255)) * 32'd4;
      end
      jump = jmp; jump_pc = jpc;
`else
      wbv = ($urandom_range(0, 2) == 0);
      wbpc = RESET_PC + 32'($urandom_range(0, 255)) * 32'd4;
      if (phase == P_WB && n_wb == 0) wbpc = 32'h3000_0040;
      wb_valid = wbv; next_pc = wbpc;
`endif

      // advance the model over the coming clock edge
      case (phase)
        P_AR: begin
          if (arready) begin
            if (n_req == 0) chk("first_araddr", araddr, 32'h3000_0000);
`ifdef CONFIG_PIPELINE_EN
            if (jpin == 1) begin
              chk("jump_araddr", araddr, 32'h3000_0100);
              jpin = 2;
            end
`else
            if (n_req == 1) chk("wb_araddr", araddr, 32'h3000_0040);
`endif
            rd_addr = cur_ar;
            rd_data = mem_word(cur_ar);
            rd_lat  = $urandom_range(0, 3);
            if (n_req == 2) rd_resp = 2'b10;
            else if (n_req == 3) rd_resp = 2'b00;
            else rd_resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            n_req++;
            phase = P_R;
          end
          if (jmp) begin want = jpc; discard = 1'b1; end
        end
        P_R: begin
          if (rvalid) begin
            if (discard || jmp) begin
              discard = 1'b0;
              if (jmp) want = jpc;
              cur_ar = want;
              phase = P_AR;
            end else begin
              ex_inst = rd_data; ex_pc = rd_addr; ex_err = (rd_resp != 2'b00);
              phase = P_OUT; fresh = 1'b1; hold_cnt = 0;
            end
          end else begin
            if (rd_lat > 0) rd_lat--;
            if (jmp) begin want = jpc; discard = 1'b1; end
          end
        end
        P_OUT: begin
          if (jmp) begin
            want = jpc; cur_ar = want; phase = P_AR;
          end else if (out_ready) begin
            n_del++;
`ifdef CONFIG_PIPELINE_EN
            want = want + 32'd4; cur_ar = want; phase = P_AR;
`else
            phase = P_WB;
`endif
          end else begin
            hold_cnt++;
          end
        end
        P_WB: begin
          if (wbv) begin
            want = wbpc; cur_ar = want; phase = P_AR; n_wb++;
          end
        end
        default: phase = P_AR;
      endcase
    end

    chk("deliveries", 32'(n_del >= 50), 32'h1);
`ifdef CONFIG_PIPELINE_EN
    chk("jump_pin_done", 32'(jpin == 3), 32'h1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
